id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID→EX pipeline register of the 5-stage RV32I pipeline CPU, with integrated load-use hazard detection.
- Captures the decoded control bundle (RegWrite, MemWrite, ALUOp, NPCOp, ALUSrc, WDSel, DMType) plus operands, immediate and PC from ID.
- Drives the stall request back to IF/ID.
- Inserts bubbles on load-use hazards and on branch/jump flush.

Parameters:
XLEN, 32, datapath width
ALUOP_W, 5, ALU operation code width
RESET_PC, 32'h0000_0000, PC value held in ex_pc after reset

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_use_rs1, id_use_rs2  in  1 each  instruction reads rs1/rs2
- id_rd1, id_rd2  in  XLEN each  register-file read data
- id_imm  in  XLEN  extended immediate
- id_regwrite, id_memwrite, id_alusrc  in  1 each  decoder controls
- id_aluop  in  ALUOP_W  ALU op
- id_npcop  in  3  NPC op; bit0 = "is branch", Zero not yet applied
- id_wdsel  in  2  writeback select; 2'b01 = load
- id_dmtype  in  3  memory access type
- ex_ready  in  1  EX can accept (0 = multicycle EX/MEM stall)
- flush  in  1  branch/jump taken, resolved in EX
- stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN each
- ex_rs1, ex_rs2, ex_rd  out  5 each
- ex_regwrite, ex_memwrite, ex_alusrc  out  1 each
- ex_aluop  out  ALUOP_W
- ex_npcop  out  3
- ex_wdsel, ex_dmtype  out  2 / 3

Behaviour:
- Reset (async, rstn=0):
  - ex_valid=0, ex_pc=RESET_PC.
  - All other registered outputs 0, i.e. a NOP bubble.
  - stall is combinational; it reads 0 while ex_valid=0.
- Hazard, combinational: `load_use = ex_valid & (ex_wdsel==2'b01) & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))`.
- stall = id_valid & load_use & ~flush.
- Register update at posedge clk, priority order:
  1. flush=1 → bubble. ex_valid=0; regwrite, memwrite, npcop, wdsel cleared. Applies regardless of ex_ready or stall.
  2. ex_ready=0 → hold every register unchanged.
  3. load_use=1 → bubble; the ID instruction is not captured (IF/ID holds it via stall).
  4. Otherwise capture all id_* fields; ex_valid=id_valid. If id_valid=0, control fields are cleared.
- Bubble invariant: ex_valid=0 implies ex_regwrite=ex_memwrite=0 and ex_npcop=0. Datapath fields may hold stale values.
- Latency: one cycle ID→EX. A load-use hazard costs exactly one bubble; stall deasserts the cycle after the bubble enters.
- A hazard against rd=x0 never stalls.
- flush and load_use in the same cycle: flush wins, stall=0.
- Reset asserted mid-stall: outputs go to the reset bubble immediately; stall drops.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Enabled:
  - Adds outputs perf_bubbles (32) and perf_flushes (32).
  - perf_bubbles increments per load-use bubble; perf_flushes per flush cycle.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Disabled: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - WDSel encodings (FROM_ALU 2'b00, FROM_MEM 2'b01, FROM_PC 2'b10).
  - NPC encodings (PLUS4 3'b000, BRANCH 3'b001, JUMP 3'b010, JALR 3'b100).
  - Control-bundle struct ctrl_t and its BUBBLE constant.
- One sub-module, hazard_load_use: purely combinational load_use/stall logic, reused by the forwarding unit's tests.

Test Plan:
1. Reset:
   - Stimulus: rstn low with random inputs.
   - Response: ex_valid=0, ex_regwrite=0, ex_pc=0, stall=0.
   - Then rstn high, id_valid=1, id_pc=0x10, id_rd=5 → next cycle ex_pc=0x10, ex_rd=5, ex_valid=1.
2. Load-use stall:
   - Stimulus: `lw x5` (wdsel=01, rd=5) enters EX, then ID holds `add x6,x5,x1` (use_rs1, rs1=5).
   - Response: stall=1 for one cycle, next ex_valid=0; following cycle add captured, stall=0.
3. No false stall:
   - Stimulus: load rd=0 followed by rs1=0; or load rd=5 followed by `lui x6` (use_rs1=0).
   - Response: stall=0, no bubble.
4. Flush priority:
   - Stimulus: flush=1 in the same cycle as a load-use hazard.
   - Response: stall=0, next ex_valid=0 and ex_regwrite=0.
5. Back-pressure:
   - Stimulus: ex_ready=0 for 3 cycles with changing id_* inputs.
   - Response: ex_* stay constant; on ex_ready=1 the current id_* is captured.
6. Feature build (ID_EX_PERF_EN):
   - Stimulus: 2 load-use hazards and 3 flush cycles.
   - Response: perf_bubbles=2, perf_flushes=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I pipeline: writeback/NPC encodings and the
// decoded control bundle carried from ID into EX.
package cpu_pkg;

    localparam int CTRL_ALUOP_W = 5;

    // Writeback select encodings
    localparam logic [1:0] FROM_ALU = 2'b00;
    localparam logic [1:0] FROM_MEM = 2'b01;
    localparam logic [1:0] FROM_PC  = 2'b10;

    // Next-PC operation encodings (bit0 marks a conditional branch)
    localparam logic [2:0] PLUS4  = 3'b000;
    localparam logic [2:0] BRANCH = 3'b001;
    localparam logic [2:0] JUMP   = 3'b010;
    localparam logic [2:0] JALR   = 3'b100;

    typedef struct packed {
        logic                    regwrite;
        logic                    memwrite;
        logic                    alusrc;
        logic [CTRL_ALUOP_W-1:0] aluop;
        logic [2:0]              npcop;
        logic [1:0]              wdsel;
        logic [2:0]              dmtype;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // Neutralise the fields that would change architectural state, keeping the rest.
    function automatic ctrl_t kill_ctrl(input ctrl_t c);
        ctrl_t k;
        k          = c;
        k.regwrite = 1'b0;
        k.memwrite = 1'b0;
        k.npcop    = PLUS4;
        k.wdsel    = FROM_ALU;
        return k;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bus: decoded instruction from ID, back-pressure/flush from EX,
// stall back to IF/ID and the registered EX-side copy.
//
// Handshake: ID presents an instruction when id_valid=1. It is consumed at a
// rising clk edge when ex_ready=1, flush=0 and stall=0; while stall=1 the
// producer must keep the same instruction on id_*. ex_ready=0 freezes the EX
// slot. flush=1 kills whatever would have entered EX, unconditionally.
interface id_ex_stage_if #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 5
);
    logic               id_valid;
    logic [XLEN-1:0]    id_pc;
    logic [4:0]         id_rs1, id_rs2, id_rd;
    logic               id_use_rs1, id_use_rs2;
    logic [XLEN-1:0]    id_rd1, id_rd2, id_imm;
    logic               id_regwrite, id_memwrite, id_alusrc;
    logic [ALUOP_W-1:0] id_aluop;
    logic [2:0]         id_npcop;
    logic [1:0]         id_wdsel;
    logic [2:0]         id_dmtype;
    logic               ex_ready;
    logic               flush;
    logic               stall;
    logic               ex_valid;
    logic [XLEN-1:0]    ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]         ex_rs1, ex_rs2, ex_rd;
    logic               ex_regwrite, ex_memwrite, ex_alusrc;
    logic [ALUOP_W-1:0] ex_aluop;
    logic [2:0]         ex_npcop;
    logic [1:0]         ex_wdsel;
    logic [2:0]         ex_dmtype;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_rd1, id_rd2, id_imm, id_regwrite, id_memwrite, id_alusrc,
               id_aluop, id_npcop, id_wdsel, id_dmtype, ex_ready, flush,
        input  stall, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2,
               ex_rd, ex_regwrite, ex_memwrite, ex_alusrc, ex_aluop, ex_npcop,
               ex_wdsel, ex_dmtype
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_rd1, id_rd2, id_imm, id_regwrite, id_memwrite, id_alusrc,
               id_aluop, id_npcop, id_wdsel, id_dmtype, ex_ready, flush,
        output stall, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2,
               ex_rd, ex_regwrite, ex_memwrite, ex_alusrc, ex_aluop, ex_npcop,
               ex_wdsel, ex_dmtype
    );
endinterface

// File: rtl/id_ex_stage_hazard_load_use.sv
// Load-use hazard detection: a load sitting in EX whose destination is read
// by the instruction in ID. x0 never creates a hazard. Purely combinational.
module hazard_load_use
    import cpu_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic [1:0] ex_wdsel_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic       flush_i,
    output logic       load_use_o,
    output logic       stall_o
);
    logic rs1_hit;
    logic rs2_hit;

    // Match either source operand against the load destination in EX
    always_comb begin
        rs1_hit    = id_use_rs1_i & (id_rs1_i == ex_rd_i);
        rs2_hit    = id_use_rs2_i & (id_rs2_i == ex_rd_i);
        load_use_o = ex_valid_i & (ex_wdsel_i == FROM_MEM) & (ex_rd_i != 5'd0)
                     & (rs1_hit | rs2_hit);
        // A flush discards the ID instruction anyway, so holding it is pointless
        stall_o    = id_valid_i & load_use_o & ~flush_i;
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with integrated load-use bubble insertion.
// Optional macro ID_EX_PERF_EN adds saturating bubble/flush counters
// (perf_bubbles, perf_flushes).
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ALUOP_W  = CTRL_ALUOP_W,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rstn,
    id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]  perf_bubbles,
    output logic [31:0]  perf_flushes
`endif
);
    logic            load_use;
    logic            stall;
    logic [ALUOP_W-1:0] id_aluop;
    ctrl_t           id_ctrl;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rd1_q, rd1_d;
    logic [XLEN-1:0] rd2_q, rd2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    ctrl_t           ctrl_q, ctrl_d;

    hazard_load_use u_hazard (
        .ex_valid_i   (valid_q),
        .ex_wdsel_i   (ctrl_q.wdsel),
        .ex_rd_i      (rd_q),
        .id_valid_i   (bus.id_valid),
        .id_rs1_i     (bus.id_rs1),
        .id_rs2_i     (bus.id_rs2),
        .id_use_rs1_i (bus.id_use_rs1),
        .id_use_rs2_i (bus.id_use_rs2),
        .flush_i      (bus.flush),
        .load_use_o   (load_use),
        .stall_o      (stall)
    );

    assign id_aluop = bus.id_aluop;

    // Pack the decoder outputs into the control bundle
    always_comb begin
        id_ctrl          = BUBBLE;
        id_ctrl.regwrite = bus.id_regwrite;
        id_ctrl.memwrite = bus.id_memwrite;
        id_ctrl.alusrc   = bus.id_alusrc;
        id_ctrl.aluop    = id_aluop;
        id_ctrl.npcop    = bus.id_npcop;
        id_ctrl.wdsel    = bus.id_wdsel;
        id_ctrl.dmtype   = bus.id_dmtype;
    end

    // Next EX slot: flush beats back-pressure beats load-use beats capture
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            ctrl_d  = kill_ctrl(ctrl_q);
        end else if (!bus.ex_ready) begin
            // EX/MEM is busy: freeze the slot
        end else if (load_use) begin
            valid_d = 1'b0;
            ctrl_d  = kill_ctrl(ctrl_q);
        end else begin
            valid_d = bus.id_valid;
            pc_d    = bus.id_pc;
            rd1_d   = bus.id_rd1;
            rd2_d   = bus.id_rd2;
            imm_d   = bus.id_imm;
            rs1_d   = bus.id_rs1;
            rs2_d   = bus.id_rs2;
            rd_d    = bus.id_rd;
            ctrl_d  = bus.id_valid ? id_ctrl : BUBBLE;
        end
    end

    // Pipeline register; reset leaves a NOP bubble at RESET_PC
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= BUBBLE;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.ex_valid    = valid_q;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_rd1      = rd1_q;
    assign bus.ex_rd2      = rd2_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_rs1      = rs1_q;
    assign bus.ex_rs2      = rs2_q;
    assign bus.ex_rd       = rd_q;
    assign bus.ex_regwrite = ctrl_q.regwrite;
    assign bus.ex_memwrite = ctrl_q.memwrite;
    assign bus.ex_alusrc   = ctrl_q.alusrc;
    assign bus.ex_aluop    = ctrl_q.aluop;
    assign bus.ex_npcop    = ctrl_q.npcop;
    assign bus.ex_wdsel    = ctrl_q.wdsel;
    assign bus.ex_dmtype   = ctrl_q.dmtype;

`ifdef ID_EX_PERF_EN
    logic [31:0] perf_bubbles_q;
    logic [31:0] perf_flushes_q;

    // Saturating counters of load-use bubbles and flush cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_bubbles_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            if (bus.flush && (perf_flushes_q != 32'hFFFF_FFFF))
                perf_flushes_q <= perf_flushes_q + 32'd1;
            if (!bus.flush && bus.ex_ready && load_use && (perf_bubbles_q != 32'hFFFF_FFFF))
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
        end
    end

    assign perf_bubbles = perf_bubbles_q;
    assign perf_flushes = perf_flushes_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage. Build with +define+ID_EX_PERF_EN to
// also exercise the performance counters.
module tb_id_ex_stage;

    localparam int W = 45;  // {valid, regwrite, memwrite, wdsel, npcop, rd, pc}
    localparam logic [W-1:0] M_FULL = {W{1'b1}};
    localparam logic [W-1:0] M_CTRL = {8'hFF, 37'b0};
    localparam int K_CAP  = 0;
    localparam int K_BUB  = 1;
    localparam int K_HOLD = 2;
    localparam int K_NONE = 3;

    typedef struct {
        int          kind;
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic        u1, u2, rw, mw;
        logic [1:0]  wd;
        logic [2:0]  np;
        logic        fl, rdy, exp_stall;
    } step_t;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];
    logic [W-1:0] last_full;

    id_ex_stage_if #(.XLEN(32), .ALUOP_W(5)) bus ();

`ifdef ID_EX_PERF_EN
    logic [31:0] perf_bubbles;
    logic [31:0] perf_flushes;
`endif

    id_ex_stage #(.XLEN(32), .ALUOP_W(5), .RESET_PC(32'h0000_0000)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef ID_EX_PERF_EN
        ,
        .perf_bubbles (perf_bubbles),
        .perf_flushes (perf_flushes)
`endif
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] mk(input logic v, input logic rw, input logic mw,
                                        input logic [1:0] wd, input logic [2:0] np,
                                        input logic [4:0] rd, input logic [31:0] pc);
        return {v, rw, mw, wd, np, rd, pc};
    endfunction

    function automatic logic [W-1:0] obs_vec();
        return {bus.ex_valid, bus.ex_regwrite, bus.ex_memwrite, bus.ex_wdsel,
                bus.ex_npcop, bus.ex_rd, bus.ex_pc};
    endfunction

    function automatic step_t mk_step(input int kind, input logic v, input logic [31:0] pc,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic u1, input logic u2,
                                      input logic rw, input logic [1:0] wd,
                                      input logic [2:0] np, input logic fl,
                                      input logic rdy, input logic exp_stall);
        step_t s;
        s.kind = kind; s.v = v; s.pc = pc; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
        s.u1 = u1; s.u2 = u2; s.rw = rw; s.mw = 1'b0; s.wd = wd; s.np = np;
        s.fl = fl; s.rdy = rdy; s.exp_stall = exp_stall;
        return s;
    endfunction

    // ---------------- driver ----------------
    // Drives one ID cycle and pushes the EX state expected after the next edge.
    task automatic drive_step(input step_t s);
        logic [W-1:0] e;
        bus.id_valid    = s.v;
        bus.id_pc       = s.pc;
        bus.id_rd       = s.rd;
        bus.id_rs1      = s.rs1;
        bus.id_rs2      = s.rs2;
        bus.id_use_rs1  = s.u1;
        bus.id_use_rs2  = s.u2;
        bus.id_rd1      = $urandom;
        bus.id_rd2      = $urandom;
        bus.id_imm      = $urandom;
        bus.id_regwrite = s.rw;
        bus.id_memwrite = s.mw;
        bus.id_alusrc   = 1'($urandom_range(0, 1));
        bus.id_aluop    = 5'($urandom_range(0, 31));
        bus.id_npcop    = s.np;
        bus.id_wdsel    = s.wd;
        bus.id_dmtype   = 3'($urandom_range(0, 7));
        bus.flush       = s.fl;
        bus.ex_ready    = s.rdy;
        case (s.kind)
            K_CAP: begin
                e = mk(s.v, s.v & s.rw, s.v & s.mw, s.v ? s.wd : 2'b00,
                       s.v ? s.np : 3'b000, s.rd, s.pc);
                last_full = e;
                exp_q.push_back(e);
                mask_q.push_back(M_FULL);
            end
            K_BUB: begin
                exp_q.push_back('0);
                mask_q.push_back(M_CTRL);
            end
            K_HOLD: begin
                exp_q.push_back(last_full);
                mask_q.push_back(M_FULL);
            end
            default: ;
        endcase
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step_t st[$];
        logic [W-1:0] e, m, o;
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.id_valid    = 1'($urandom_range(0, 1));
            bus.id_pc       = $urandom;
            bus.id_rd       = 5'($urandom_range(0, 31));
            bus.id_rs1      = 5'($urandom_range(0, 31));
            bus.id_rs2      = 5'($urandom_range(0, 31));
            bus.id_use_rs1  = 1'($urandom_range(0, 1));
            bus.id_use_rs2  = 1'($urandom_range(0, 1));
            bus.id_rd1      = $urandom;
            bus.id_rd2      = $urandom;
            bus.id_imm      = $urandom;
            bus.id_regwrite = 1'($urandom_range(0, 1));
            bus.id_memwrite = 1'($urandom_range(0, 1));
            bus.id_alusrc   = 1'($urandom_range(0, 1));
            bus.id_aluop    = 5'($urandom_range(0, 31));
            bus.id_npcop    = 3'($urandom_range(0, 7));
            bus.id_wdsel    = 2'($urandom_range(0, 3));
            bus.id_dmtype   = 3'($urandom_range(0, 7));
            bus.flush       = 1'($urandom_range(0, 1));
            bus.ex_ready    = 1'($urandom_range(0, 1));
        end
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), {W{1'b0}});
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b want 0", bus.stall);
        end
        @(negedge clk);
        rstn = 1'b1;
        st.push_back(mk_step(K_CAP, 1, 32'h10, 5, 0, 0, 0, 0, 1, 2'b00, 3'b000, 0, 1, 0));
        foreach (st[i]) begin
            if (i != 0) @(negedge clk);
            drive_step(st[i]);
            #1;
            checks++;
            if (bus.stall !== st[i].exp_stall) begin
                errors++;
                $display("FAIL reset_first stall %0d: got %b want %b", i, bus.stall, st[i].exp_stall);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front(); m = mask_q.pop_front(); o = obs_vec();
            checks++;
            if ((o & m) !== (e & m)) begin
                errors++;
                $display("FAIL reset_first ex %0d: got %h want %h mask %h", i, o, e, m);
            end
        end
    endtask

    task automatic test_load_use();
        step_t st[$];
        logic [W-1:0] e, m, o;
        st.push_back(mk_step(K_CAP, 1, 32'h20, 5, 2, 0, 1, 0, 1, 2'b01, 3'b000, 0, 1, 0));
        st.push_back(mk_step(K_BUB, 1, 32'h24, 6, 5, 1, 1, 1, 1, 2'b00, 3'b000, 0, 1, 1));
        st.push_back(mk_step(K_CAP, 1, 32'h24, 6, 5, 1, 1, 1, 1, 2'b00, 3'b000, 0, 1, 0));
        st.push_back(mk_step(K_CAP, 1, 32'h28, 7, 3, 0, 1, 0, 1, 2'b01, 3'b000, 0, 1, 0));
        st.push_back(mk_step(K_BUB, 1, 32'h2c, 0, 1, 7, 1, 1, 0, 2'b00, 3'b000, 0, 1, 1));
        st.push_back(mk_step(K_CAP, 1, 32'h2c, 0, 1, 7, 1, 1, 0, 2'b00, 3'b000, 0, 1, 0));
        foreach (st[i]) begin
            @(negedge clk);
            drive_step(st[i]);
            #1;
            checks++;
            if (bus.stall !== st[i].exp_stall) begin
                errors++;
                $display("FAIL load_use stall %0d: got %b want %b", i, bus.stall, st[i].exp_stall);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front(); m = mask_q.pop_front(); o = obs_vec();
            checks++;
            if ((o & m) !== (e & m)) begin
                errors++;
                $display("FAIL load_use ex %0d: got %h want %h mask %h", i, o, e, m);
            end
        end
    endtask

    task automatic test_no_false_stall();
        step_t st[$];
        logic [W-1:0] e, m, o;
        st.push_back(mk_step(K_CAP, 1, 32'h30, 0, 3, 0, 1, 0, 1, 2'b01, 3'b000, 0, 1, 0));
        st.push_back(mk_step(K_CAP, 1, 32'h34, 7, 0, 0, 1, 1, 1, 2'b00, 3'b000, 0, 1, 0));
        st.push_back(mk_step(K_CAP, 1, 32'h38, 5, 1, 0, 1, 0, 1, 2'b01, 3'b000, 0, 1, 0));
        st.push_back(mk_step(K_CAP, 1, 32'h3c, 6, 5, 5, 0, 0, 1, 2'b00, 3'b000, 0, 1, 0));
        st.push_back(mk_step(K_CAP, 1, 32'h40, 5, 2, 0, 1, 0, 1, 2'b01, 3'b000, 0, 1, 0));
        st.push_back(mk_step(K_BUB, 0, 32'h44, 6, 5, 0, 1, 0, 1, 2'b00, 3'b000, 0, 1, 0));
        foreach (st[i]) begin
            @(negedge clk);
            drive_step(st[i]);
            #1;
            checks++;
            if (bus.stall !== st[i].exp_stall) begin
                errors++;
                $display("FAIL no_false_stall stall %0d: got %b want %b", i, bus.stall, st[i].exp_stall);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front(); m = mask_q.pop_front(); o = obs_vec();
            checks++;
            if ((o & m) !== (e & m)) begin
                errors++;
                $display("FAIL no_false_stall ex %0d: got %h want %h mask %h", i, o, e, m);
            end
        end
    endtask

    task automatic test_flush_priority();
        step_t st[$];
        logic [W-1:0] e, m, o;
        st.push_back(mk_step(K_CAP, 1, 32'h50, 5, 1, 0, 1, 0, 1, 2'b01, 3'b000, 0, 1, 0));
        st.push_back(mk_step(K_BUB, 1, 32'h54, 6, 5, 0, 1, 0, 1, 2'b00, 3'b000, 1, 1, 0));
        st.push_back(mk_step(K_CAP, 1, 32'h58, 8, 5, 0, 1, 0, 1, 2'b00, 3'b000, 0, 1, 0));
        st.push_back(mk_step(K_BUB, 1, 32'h5c, 9, 1, 2, 1, 1, 1, 2'b00, 3'b000, 1, 0, 0));
        st.push_back(mk_step(K_CAP, 1, 32'h60, 9, 1, 2, 1, 1, 1, 2'b10, 3'b001, 0, 1, 0));
        st.push_back(mk_step(K_BUB, 1, 32'h64, 4, 1, 2, 1, 1, 1, 2'b00, 3'b000, 1, 1, 0));
        st.push_back(mk_step(K_CAP, 1, 32'h68, 10, 1, 2, 1, 1, 1, 2'b00, 3'b000, 0, 1, 0));
        foreach (st[i]) begin
            @(negedge clk);
            drive_step(st[i]);
            #1;
            checks++;
            if (bus.stall !== st[i].exp_stall) begin
                errors++;
                $display("FAIL flush_priority stall %0d: got %b want %b", i, bus.stall, st[i].exp_stall);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front(); m = mask_q.pop_front(); o = obs_vec();
            checks++;
            if ((o & m) !== (e & m)) begin
                errors++;
                $display("FAIL flush_priority ex %0d: got %h want %h mask %h", i, o, e, m);
            end
        end
        bus.flush = 1'b0;
    endtask

    task automatic test_back_pressure();
        step_t st[$];
        logic [W-1:0] e, m, o;
        st.push_back(mk_step(K_CAP, 1, 32'h70, 9, 1, 2, 1, 1, 1, 2'b00, 3'b010, 0, 1, 0));
        for (int k = 0; k < 3; k++)
            st.push_back(mk_step(K_HOLD, 1'($urandom_range(0, 1)), 32'h80 + 32'(4 * k),
                                 5'(10 + k), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                                 1, 1, 1'($urandom_range(0, 1)), 2'b10,
                                 3'($urandom_range(0, 7)), 0, 0, 0));
        st.push_back(mk_step(K_CAP, 1, 32'h90, 13, 3, 4, 1, 1, 0, 2'b10, 3'b100, 0, 1, 0));
        foreach (st[i]) begin
            @(negedge clk);
            drive_step(st[i]);
            #1;
            checks++;
            if (bus.stall !== st[i].exp_stall) begin
                errors++;
                $display("FAIL back_pressure stall %0d: got %b want %b", i, bus.stall, st[i].exp_stall);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front(); m = mask_q.pop_front(); o = obs_vec();
            checks++;
            if ((o & m) !== (e & m)) begin
                errors++;
                $display("FAIL back_pressure ex %0d: got %h want %h mask %h", i, o, e, m);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t st[$];
        step_t s;
        logic [W-1:0] e, m, o;
        for (int k = 0; k < 20; k++) begin
            s = mk_step(K_CAP, 1'($urandom_range(0, 1)), 32'h100 + 32'(4 * k),
                        5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00,
                        3'($urandom_range(0, 7)), 0, 1, 0);
            s.mw = 1'($urandom_range(0, 1));
            st.push_back(s);
        end
        foreach (st[i]) begin
            @(negedge clk);
            drive_step(st[i]);
            #1;
            checks++;
            if (bus.stall !== st[i].exp_stall) begin
                errors++;
                $display("FAIL back_to_back stall %0d: got %b want %b", i, bus.stall, st[i].exp_stall);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front(); m = mask_q.pop_front(); o = obs_vec();
            checks++;
            if ((o & m) !== (e & m)) begin
                errors++;
                $display("FAIL back_to_back ex %0d: got %h want %h mask %h", i, o, e, m);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [W-1:0] e, m, o;
        @(negedge clk);
        drive_step(mk_step(K_CAP, 1, 32'hA0, 5, 1, 0, 1, 0, 1, 2'b01, 3'b000, 0, 1, 0));
        @(posedge clk); #1;
        e = exp_q.pop_front(); m = mask_q.pop_front(); o = obs_vec();
        checks++;
        if ((o & m) !== (e & m)) begin
            errors++;
            $display("FAIL reset_mid_stall load: got %h want %h", o, e);
        end
        @(negedge clk);
        drive_step(mk_step(K_NONE, 1, 32'hA4, 6, 5, 0, 1, 0, 1, 2'b00, 3'b000, 0, 1, 1));
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_stall pre: stall got %b want 1", bus.stall);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_mid_stall state: got %h want %h", obs_vec(), {W{1'b0}});
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall stall: got %b want 0", bus.stall);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

`ifdef ID_EX_PERF_EN
    task automatic test_perf();
        step_t st[$];
        logic [W-1:0] e, m, o;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        st.push_back(mk_step(K_CAP, 1, 32'h200, 5, 1, 0, 1, 0, 1, 2'b01, 3'b000, 0, 1, 0));
        st.push_back(mk_step(K_BUB, 1, 32'h204, 6, 5, 0, 1, 0, 1, 2'b00, 3'b000, 0, 1, 1));
        st.push_back(mk_step(K_CAP, 1, 32'h204, 6, 5, 0, 1, 0, 1, 2'b00, 3'b000, 0, 1, 0));
        st.push_back(mk_step(K_CAP, 1, 32'h208, 7, 1, 0, 1, 0, 1, 2'b01, 3'b000, 0, 1, 0));
        st.push_back(mk_step(K_BUB, 1, 32'h20c, 8, 1, 7, 1, 1, 1, 2'b00, 3'b000, 0, 1, 1));
        st.push_back(mk_step(K_CAP, 1, 32'h20c, 8, 1, 7, 1, 1, 1, 2'b00, 3'b000, 0, 1, 0));
        for (int k = 0; k < 3; k++)
            st.push_back(mk_step(K_BUB, 1, 32'h210, 9, 1, 2, 1, 1, 1, 2'b00, 3'b000, 1, 1, 0));
        foreach (st[i]) begin
            @(negedge clk);
            drive_step(st[i]);
            #1;
            checks++;
            if (bus.stall !== st[i].exp_stall) begin
                errors++;
                $display("FAIL perf stall %0d: got %b want %b", i, bus.stall, st[i].exp_stall);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front(); m = mask_q.pop_front(); o = obs_vec();
            checks++;
            if ((o & m) !== (e & m)) begin
                errors++;
                $display("FAIL perf ex %0d: got %h want %h mask %h", i, o, e, m);
            end
        end
        bus.flush = 1'b0;
        checks++;
        if (perf_bubbles !== 32'd2) begin
            errors++;
            $display("FAIL perf_bubbles: got %0d want 2", perf_bubbles);
        end
        checks++;
        if (perf_flushes !== 32'd3) begin
            errors++;
            $display("FAIL perf_flushes: got %0d want 3", perf_flushes);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        last_full = '0;
        rstn      = 1'b0;
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_flush_priority();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef ID_EX_PERF_EN
        test_perf();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
